iommu_ptw: RTL
==============

# iommu_ptw

Sv39 page-table walker that sits directly upstream of `iommu_ioatc`. On an ATC miss it accepts the faulting IOVA, walks the in-memory page table through a single-outstanding read port, and refills the ATC through its update port (`new_iova`/`new_pa`/`update_ready`/`update_done`). It then returns the translated PA, or a fault, to the requester.

## Interface
- `LEVELS`, 3: page-table depth (Sv39); fixed, not for override.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: walk request.
- `req_ready` out 1: high only in IDLE.
- `req_iova` in 64: IOVA to translate.
- `root_ppn` in 44: PPN of the root table; sampled at request accept.
- `mem_req_valid` out 1: PTE read request.
- `mem_req_ready` in 1: read request accepted.
- `mem_req_addr` out 64: PTE byte address, 8-byte aligned.
- `mem_resp_valid` in 1: read data valid.
- `mem_resp_data` in 64: PTE.
- `upd_valid` out 1: one-cycle pulse to ATC `update_ready`.
- `upd_iova` out 64: to ATC `new_iova`.
- `upd_pa` out 64: to ATC `new_pa`.
- `upd_done` in 1: from ATC `update_done`.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_pa` out 64: translated PA, valid with `resp_valid`.
- `resp_fault` out 1: walk faulted, valid with `resp_valid`.

## Operation
- States: IDLE, REQ, WAIT, CHECK, UPDT, UWAIT, RESP.
- **IDLE:** on `req_valid`, capture `req_iova` and `root_ppn`; set level=2, table ppn=`root_ppn`.
  - If `req_iova[63:39]` is not all equal to `req_iova[38]`, go to RESP with fault.
  - Otherwise go to REQ.
- **REQ:** drive `mem_req_valid`=1 and `mem_req_addr` = {ppn,12'b0} + vpn[level]*8, where vpn2=iova[38:30], vpn1=iova[29:21], vpn0=iova[20:12]. Hold both until `mem_req_ready`, then go to WAIT.
- **WAIT:** on `mem_resp_valid`, register `mem_resp_data` as the PTE and go to CHECK. `mem_resp_valid` is ignored in every other state.
- **CHECK:** the PTE fields are V=bit0, R=bit1, W=bit2, X=bit3, ppn=bits[53:10]. Evaluate in this order:
  - V=0, or R=0 with W=1: fault, go to RESP.
  - R=1 or X=1 (leaf):
    - If level=2 and ppn[17:0]≠0, or level=1 and ppn[8:0]≠0: misaligned superpage, fault.
    - Otherwise form PA[55:0]:
      - level 0: {ppn, off}
      - level 1: {ppn[43:9], vpn0, off}
      - level 2: {ppn[43:18], vpn1, vpn0, off}
    - Bits [63:56] of the PA are 0. Go to UPDT.
  - Non-leaf at level 0: fault.
  - Non-leaf at level 1 or 2: ppn becomes the next table, level-1, go to REQ.
- **UPDT:** `upd_valid`=1 for exactly one cycle, with `upd_iova`=captured IOVA and `upd_pa`=PA. Go to UWAIT. Superpages fill the ATC as a single 4 KiB entry.
- **UWAIT:** hold `upd_iova` and `upd_pa` stable; on `upd_done`, go to RESP.
- **RESP:** `resp_valid`=1 for one cycle, with `resp_pa`=PA and `resp_fault`=0, or `resp_pa`=0 and `resp_fault`=1. Go to IDLE.
- Faults never assert `upd_valid`.
- A new request is accepted only in IDLE; `req_valid` is ignored while busy.

## Timing
- **Reset:** state=IDLE. `req_ready`=1. `mem_req_valid`, `upd_valid`, `resp_valid` and `resp_fault`=0. `mem_req_addr`, `upd_iova`, `upd_pa` and `resp_pa`=0.
- **Reset mid-walk:** abandons the walk immediately. A late `mem_resp_valid` or `upd_done` arriving in IDLE is ignored.
- **Per level:** REQ(≥1) + WAIT(≥1) + CHECK(1).
- **Best case, 4 KiB walk** (ready=1, response one cycle after handshake), with accept in cycle 0:
  - `mem_req_valid` in cycles 1, 4 and 7.
  - `upd_valid` in cycle 10.
  - `resp_valid` in the cycle after `upd_done` is sampled. With the ATC, `upd_done` is high in cycle 12 and `resp_valid` in cycle 13.
- **Non-canonical fault:** `resp_valid` in cycle 1; no memory read is issued.
- **Address arithmetic:** 64-bit; the ppn is zero-extended.

## Test plan
- **4 KiB walk.** root_ppn=0x80000, iova=0x40201ABC. PTEs 0x20000401 @0x80000008, 0x20000801 @0x80001008, 0x240000CF @0x80002008.
  - Required: read addresses in exactly that order, then `upd_valid` with `upd_pa`=0x90000ABC and `upd_iova`=0x40201ABC, then `resp_pa`=0x90000ABC with `resp_fault`=0.
- **2 MiB superpage.** Same as above, but the level-1 PTE is 0x240000CF.
  - Required: only two reads, `upd_pa`=`resp_pa`=0x90001ABC.
- **Faults.**
  - Level-2 PTE=0: `resp_fault`=1, no `upd_valid`.
  - Level-1 PTE 0x240004CF (misaligned superpage): fault.
  - Level-0 PTE 0x20000C01 (non-leaf): fault.
  - Level-2 PTE 0x00000005 (W without R): fault.
- **Non-canonical IOVA.** iova=0xFFFF000000001000: `resp_fault`=1 in cycle 1, `mem_req_valid` never asserted.
- **Backpressure.**
  - Hold `mem_req_ready`=0 for 5 cycles: `mem_req_addr` stays stable.
  - Delay `mem_resp_valid` by 7 cycles: same result as the 4 KiB walk.
  - Delay `upd_done` by 4 cycles: `resp_valid` comes one cycle after `upd_done`.
  - `req_valid` pulsed while busy: ignored.
- **Reset mid-walk.** Assert `rst_n`=0 during the second WAIT.
  - Required: all outputs at reset values asynchronously.
  - A `mem_resp_valid` arriving after reset is released is ignored.
  - The next request walks normally.

Source files
------------

// File: rtl/iommu_ptw.sv
`default_nettype none
// ============================================================================
// Module      : iommu_ptw
// Description : Sv39 page-table walker that refills iommu_ioatc on a miss and
//               returns the translated PA or a fault to the requester.
// Revision    : 1.0 - initial release
// ============================================================================
module iommu_ptw #(
  parameter int LEVELS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_iova,
  input  logic [43:0] root_ppn,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output logic        upd_valid,
  output logic [63:0] upd_iova,
  output logic [63:0] upd_pa,
  input  logic        upd_done,
  output logic        resp_valid,
  output logic [63:0] resp_pa,
  output logic        resp_fault
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_REQ   = 3'd1;
  localparam logic [2:0] c_WAIT  = 3'd2;
  localparam logic [2:0] c_CHECK = 3'd3;
  localparam logic [2:0] c_UPDT  = 3'd4;
  localparam logic [2:0] c_UWAIT = 3'd5;
  localparam logic [2:0] c_RESP  = 3'd6;

  localparam logic [1:0] c_TOP_LEVEL = 2'(LEVELS - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [63:0] r_iova;
  logic [43:0] r_ppn;
  logic [1:0]  r_level;
  logic [43:0] r_pte_ppn;
  logic [3:0]  r_pte_flags;
  logic [63:0] r_pa;
  logic        r_fault;

  logic        w_noncanon;
  logic [8:0]  w_vpn;
  logic [63:0] w_pte_addr;
  logic        w_bad;
  logic        w_leaf;
  logic        w_misalign;
  logic        w_check_fault;
  logic        w_check_leaf;
  logic [63:0] w_leaf_pa;
  logic        w_unused_pte;

  // Bits outside V/R/W/X and the PPN carry nothing the walker acts on.
  assign w_unused_pte = ^{mem_resp_data[63:54], mem_resp_data[9:4]};

  assign w_noncanon = (req_iova[63:39] != {25{req_iova[38]}});

  always_comb begin
    case (r_level)
      2'd2:    w_vpn = r_iova[38:30];
      2'd1:    w_vpn = r_iova[29:21];
      default: w_vpn = r_iova[20:12];
    endcase
  end

  assign w_pte_addr = {8'b0, r_ppn, 12'b0} + {52'b0, w_vpn, 3'b000};

  assign w_bad      = !r_pte_flags[0] || (!r_pte_flags[1] && r_pte_flags[2]);
  assign w_leaf     = r_pte_flags[1] || r_pte_flags[3];
  assign w_misalign = ((r_level == 2'd2) && (r_pte_ppn[17:0] != 18'd0)) ||
                      ((r_level == 2'd1) && (r_pte_ppn[8:0]  != 9'd0));

  assign w_check_fault = w_bad || (w_leaf && w_misalign) ||
                         (!w_leaf && (r_level == 2'd0));
  assign w_check_leaf  = !w_bad && w_leaf && !w_misalign;

  // Superpages keep the low VPN fields from the IOVA.
  always_comb begin
    case (r_level)
      2'd2:    w_leaf_pa = {8'b0, r_pte_ppn[43:18], r_iova[29:12], r_iova[11:0]};
      2'd1:    w_leaf_pa = {8'b0, r_pte_ppn[43:9], r_iova[20:12], r_iova[11:0]};
      default: w_leaf_pa = {8'b0, r_pte_ppn, r_iova[11:0]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (req_valid) w_next_state = w_noncanon ? c_RESP : c_REQ;
      c_REQ:   if (mem_req_ready) w_next_state = c_WAIT;
      c_WAIT:  if (mem_resp_valid) w_next_state = c_CHECK;
      c_CHECK: begin
        if (w_check_fault)     w_next_state = c_RESP;
        else if (w_check_leaf) w_next_state = c_UPDT;
        else                   w_next_state = c_REQ;
      end
      c_UPDT:  w_next_state = c_UWAIT;
      c_UWAIT: if (upd_done) w_next_state = c_RESP;
      c_RESP:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = 64'd0;
    upd_valid     = 1'b0;
    upd_iova      = 64'd0;
    upd_pa        = 64'd0;
    resp_valid    = 1'b0;
    resp_pa       = 64'd0;
    resp_fault    = 1'b0;
    case (r_state)
      c_IDLE: req_ready = 1'b1;
      c_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = w_pte_addr;
      end
      c_UPDT: begin
        upd_valid = 1'b1;
        upd_iova  = r_iova;
        upd_pa    = r_pa;
      end
      c_UWAIT: begin
        upd_iova = r_iova;
        upd_pa   = r_pa;
      end
      c_RESP: begin
        resp_valid = 1'b1;
        resp_fault = r_fault;
        resp_pa    = r_fault ? 64'd0 : r_pa;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iova      <= 64'd0;
      r_ppn       <= 44'd0;
      r_level     <= 2'd0;
      r_pte_ppn   <= 44'd0;
      r_pte_flags <= 4'd0;
      r_pa        <= 64'd0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: if (req_valid) begin
          r_iova  <= req_iova;
          r_ppn   <= root_ppn;
          r_level <= c_TOP_LEVEL;
          r_pa    <= 64'd0;
          r_fault <= w_noncanon;
        end
        c_WAIT: if (mem_resp_valid) begin
          r_pte_ppn   <= mem_resp_data[53:10];
          r_pte_flags <= mem_resp_data[3:0];
        end
        c_CHECK: begin
          if (w_check_fault) begin
            r_fault <= 1'b1;
          end else if (w_check_leaf) begin
            r_pa <= w_leaf_pa;
          end else begin
            r_ppn   <= r_pte_ppn;
            r_level <= r_level - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
